dmem_responder: RTL and testbench

// - Data-memory responder: the memory side of the pipeline load/store interface.
// - Accepts one load/store request at a time from the memory stage over a valid/ready handshake.
// - Applies programmable wait states, then returns read data and error status on a held response channel.
// - Includes a full-word backdoor port for testbench preload and checking.

---
 rtl/rv32i_pkg.sv | 25 ++
 rtl/dmem_array.sv | 43 ++++
 rtl/dmem_responder.sv | 120 ++++++++++++
 tb/tb_dmem_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: types and widths shared between the pipeline memory stage and
// the data-memory responder.
//   DPW           data width
//   ADW           address width
//   dmem_req_t    load/store request as latched by the responder
//   dmem_state_e  responder FSM states
package rv32i_pkg;

    localparam int DPW = 32;
    localparam int ADW = 32;

    typedef struct packed {
        logic           we;
        logic [3:0]     be;
        logic [ADW-1:0] addr;
        logic [DPW-1:0] wdata;
    } dmem_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 word storage, no reset.
//   clk              clock
//   we1/be1/waddr1/wdata1  byte-enabled write port (pipeline store)
//   we2/waddr2/wdata2      full-word write port (backdoor), lands after port 1
//   raddr_a/rdata_a        combinational read (pipeline load)
//   raddr_b/rdata_b        combinational read (backdoor)
module dmem_array
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we1,
    input  logic [3:0]     be1,
    input  logic [AW-1:0]  waddr1,
    input  logic [DPW-1:0] wdata1,
    input  logic           we2,
    input  logic [AW-1:0]  waddr2,
    input  logic [DPW-1:0] wdata2,
    input  logic [AW-1:0]  raddr_a,
    output logic [DPW-1:0] rdata_a,
    input  logic [AW-1:0]  raddr_b,
    output logic [DPW-1:0] rdata_b
);

    logic [DPW-1:0] mem [DEPTH];

    // Port 2 is written after port 1 in the same block, so on a same-word
    // collision the backdoor word overrides the store bytes.
    always_ff @(posedge clk) begin
        if (we1) begin
            for (int b = 0; b < 4; b++) begin
                if (be1[b]) mem[waddr1][8*b +: 8] <= wdata1[8*b +: 8];
            end
        end
        if (we2) mem[waddr2] <= wdata2;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory side of the pipeline load/store interface.
// One request at a time; WAIT_STATES extra cycles per access; response held
// until consumed.
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              request handshake
//   req_we/req_be/req_addr/req_wdata request fields
//   rsp_valid/rsp_ready              response handshake
//   rsp_rdata/rsp_err                load data (0 for stores/errors), error
//   bd_en/bd_addr/bd_wdata/bd_rdata  full-word backdoor write / comb. read
module dmem_responder
    import rv32i_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_we,
    input  logic [3:0]     req_be,
    input  logic [DPW-1:0] req_addr,
    input  logic [DPW-1:0] req_wdata,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [DPW-1:0] rsp_rdata,
    output logic           rsp_err,
    input  logic           bd_en,
    input  logic [DPW-1:0] bd_addr,
    input  logic [DPW-1:0] bd_wdata,
    output logic [DPW-1:0] bd_rdata
);

    localparam int AW = $clog2(DEPTH);

    dmem_state_e    state;
    logic [3:0]     wait_cnt;
    dmem_req_t      req_q;
    logic           err_q;
    logic           addr_err;
    logic           commit;
    logic           mem_we;
    logic [DPW-1:0] load_word;
    logic           unused_addr_bits;

    // Misaligned, or any address bit above the array's word index is set.
    assign addr_err = (req_addr[1:0] != 2'b00) || ((req_addr >> (AW + 2)) != '0);

    // Final ACCESS cycle: the memory is touched exactly on this edge.
    assign commit = (state == ST_ACCESS) && (wait_cnt == 4'd0);
    assign mem_we = commit && req_q.we && !err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            req_q     <= '0;
            err_q     <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_q     <= '{we: req_we, be: req_be, addr: req_addr, wdata: req_wdata};
                        err_q     <= addr_err;
                        wait_cnt  <= 4'(WAIT_STATES);
                        req_ready <= 1'b0;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        rsp_rdata <= (!req_q.we && !err_q) ? load_word : '0;
                        rsp_err   <= err_q;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // req_ready rises only after the response leaves, so a
                    // new request is taken one cycle later at the earliest.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we1     (mem_we),
        .be1     (req_q.be),
        .waddr1  (req_q.addr[AW+1:2]),
        .wdata1  (req_q.wdata),
        .we2     (bd_en),
        .waddr2  (bd_addr[AW+1:2]),
        .wdata2  (bd_wdata),
        .raddr_a (req_q.addr[AW+1:2]),
        .rdata_a (load_word),
        .raddr_b (bd_addr[AW+1:2]),
        .rdata_b (bd_rdata)
    );

    // Address bits outside the word index only feed the error flag.
    assign unused_addr_bits = ^{bd_addr[DPW-1:AW+2], bd_addr[1:0],
                                req_q.addr[DPW-1:AW+2], req_q.addr[1:0]};

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scoreboard bench for dmem_responder.
// Stimulus pushes expected responses (from a word-array reference model);
// a negedge monitor drives rsp_ready and pops/compares on each response.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int WS    = 1;
    localparam int NW    = 80;   // words preloaded and tracked by the model

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0, bd_en = 1'b0;
    logic [3:0]  req_be = 4'h0;
    logic [31:0] req_addr = '0, req_wdata = '0, bd_addr = '0, bd_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, bd_rdata;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bd_en(bd_en), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] rdata; logic err; int hs; } exp_t;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] model [NW];
    int          checks = 0, failures = 0, cyc = 0, rr_mode = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic ref_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
    endfunction

    // Drive one request, wait for acceptance, record what it must return.
    task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] a,
                         input logic [31:0] d);
        int   n = 0;
        exp_t e;
        int   w;
        @(negedge clk);
        req_we = we; req_be = be; req_addr = a; req_wdata = d; req_valid = 1'b1;
        while (!req_ready && n < 500) begin @(negedge clk); n++; end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL req_accept_timeout: got no req_ready expected acceptance");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        w       = int'(a >> 2);
        e.hs    = cyc;
        e.err   = ref_err(a);
        e.rdata = (!we && !e.err) ? model[w] : 32'h0;
        sb.push_back(e);
        if (we && !e.err) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) model[w][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic bd_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_en = 1'b1; bd_addr = a; bd_wdata = d;
        @(posedge clk); #1;
        bd_en = 1'b0;
        model[int'(a >> 2)] = d;
    endtask

    task automatic bd_check(input string name, input logic [31:0] a);
        @(negedge clk);
        bd_addr = a;
        #1 check(name, bd_rdata, model[int'(a >> 2)]);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 2000) begin @(negedge clk); n++; end
        check("drain_empty", 32'(sb.size()), 32'h0);
    endtask

    // Monitor: protocol checks, rsp_ready generation and scoreboard pops.
    logic        prev_v = 1'b0, prev_e = 1'b0, took = 1'b0;
    logic [31:0] prev_d = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
            took   = 1'b0;
        end else begin
            if (took) check("idle_after_rsp", {30'h0, rsp_valid, req_ready}, 32'h1);
            took = 1'b0;
            if (rsp_valid) begin
                check("no_accept_in_resp", {31'h0, req_ready}, 32'h0);
                if (!prev_v) begin
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_rsp: got response expected none");
                    end else begin
                        check("latency", 32'(cyc - sb[0].hs), 32'(1 + WS));
                    end
                end else begin
                    check("hold_rdata", rsp_rdata, prev_d);
                    check("hold_err", {31'h0, rsp_err}, {31'h0, prev_e});
                end
            end
            case (rr_mode)
                0:       rsp_ready = ($urandom_range(0, 3) != 0);
                1:       rsp_ready = 1'b1;
                default: rsp_ready = 1'b0;
            endcase
            if (rsp_valid && rsp_ready && sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, mon_e.rdata);
                check("rsp_err", {31'h0, rsp_err}, {31'h0, mon_e.err});
                took = 1'b1;
            end
            prev_v = rsp_valid;
            prev_d = rsp_rdata;
            prev_e = rsp_err;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [31:0] a;
        int r;

        // Reset values.
        #12;
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < NW; i++) bd_write(32'(i * 4), $urandom);

        // Basic load after backdoor preload.
        rr_mode = 1;
        bd_write(32'h100, 32'hDEADBEEF);
        issue(1'b0, 4'h0, 32'h100, 32'h0);
        drain();

        // Partial byte-enable store.
        bd_write(32'h104, 32'h11223344);
        issue(1'b1, 4'b0101, 32'h104, 32'hAABBCCDD);
        drain();
        bd_check("be_merge", 32'h104);
        check("be_merge_const", model[32'h104 >> 2], 32'h11BB33DD);

        // Errors: misaligned, out of range, errored store, be==0 store.
        issue(1'b0, 4'h0, 32'h102, 32'h0);
        issue(1'b0, 4'h0, 32'h400, 32'h0);
        issue(1'b1, 4'hF, 32'h400, 32'h55555555);
        issue(1'b1, 4'h0, 32'h110, 32'h77777777);
        drain();
        bd_check("err_store_word0", 32'h0);

        // Held response; a pending request must wait.
        rr_mode = 2;
        issue(1'b0, 4'h0, 32'h100, 32'h0);
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        check("hold_rsp_seen", {31'h0, rsp_valid}, 32'h1);
        req_we = 1'b0; req_addr = 32'h104; req_valid = 1'b1;
        repeat (5) @(negedge clk);
        rr_mode = 1;
        issue(1'b0, 4'h0, 32'h104, 32'h0);
        drain();

        // Store colliding with backdoor on the commit edge: backdoor wins.
        issue(1'b1, 4'hF, 32'h108, 32'h1);
        repeat (1 + WS) @(negedge clk);
        bd_en = 1'b1; bd_addr = 32'h108; bd_wdata = 32'h2;
        @(posedge clk); #1 bd_en = 1'b0;
        model[32'h108 >> 2] = 32'h2;
        drain();
        bd_check("collide_store", 32'h108);

        // Load colliding with backdoor: returns pre-edge data (2).
        issue(1'b0, 4'h0, 32'h108, 32'h0);
        repeat (1 + WS) @(negedge clk);
        bd_en = 1'b1; bd_addr = 32'h108; bd_wdata = 32'h3;
        @(posedge clk); #1 bd_en = 1'b0;
        model[32'h108 >> 2] = 32'h3;
        drain();
        bd_check("collide_load_after", 32'h108);

        // Randomized traffic with random backpressure.
        rr_mode = 0;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'($urandom_range(0, NW - 1) * 4 + $urandom_range(1, 3));
            else if (r == 1) a = $urandom | 32'h400;
            else             a = 32'($urandom_range(0, NW - 1) * 4);
            issue(1'($urandom), 4'($urandom), a, $urandom);
        end
        rr_mode = 1;
        drain();
        for (int i = 0; i < NW; i++) bd_check("final_mem", 32'(i * 4));

        // Reset during ACCESS of a store: aborted, no write.
        @(negedge clk);
        req_we = 1'b1; req_be = 4'hF; req_addr = 32'h10C; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 req_valid = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("abort_req_ready", {31'h0, req_ready}, 32'h1);
        bd_check("abort_no_write", 32'h10C);

        issue(1'b0, 4'h0, 32'h10C, 32'h0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
